// File: rtl/gb_pkg.sv
// Shared Game Boy bus definitions: register addresses,
// OAM geometry and the DMA state encoding.
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN      = 160;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_DELAY,
        DMA_XFER
    } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// DMA memory bus: read request port towards ROM/RAM
// and write port into OAM.
interface oam_dma_if;

    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;

    modport master (
        output rd_en, rd_addr,
        output oam_we, oam_addr, oam_wdata,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr,
        input  oam_we, oam_addr, oam_wdata,
        output rd_data
    );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies XX00..XX(OAM_LEN-1) into OAM after
// a write to the DMA register, one byte per BYTE_CYCLES clocks.
module oam_dma
    import gb_pkg::dma_state_t, gb_pkg::DMA_IDLE;
    import gb_pkg::DMA_DELAY, gb_pkg::DMA_XFER;
#(
    parameter int BYTE_CYCLES = 4,
    parameter int START_DELAY = 4,
    parameter int OAM_LEN     = gb_pkg::OAM_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_we,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       busy,
    oam_dma_if.master  bus
);

    localparam int SW = $clog2(BYTE_CYCLES);
    localparam int DW = $clog2(START_DELAY + 1);

    localparam logic [SW-1:0] SUB_LAST = SW'(BYTE_CYCLES - 1);
    localparam logic [SW-1:0] SUB_WR   = SW'(1);
    localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
    localparam logic [7:0]    IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_t    state_q, state_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    idx_q, idx_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          pend_q;
    logic [7:0]    pidx_q;
    logic [7:0]    rdata_q;
    logic [15:0]   raddr_q;
    logic [7:0]    oaddr_q;
    logic [7:0]    wdata_q;

    logic          rd_en_c;
    logic [15:0]   rd_addr_c;
    logic [7:0]    oam_addr_c;
    logic [7:0]    oam_wdata_c;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        dly_d   = dly_q;
        case (state_q)
            DMA_DELAY: begin
                if (dly_q == DLY_LAST) begin
                    state_d = DMA_XFER;
                    idx_d   = '0;
                    sub_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            DMA_XFER: begin
                if (sub_q == SUB_WR && idx_q == IDX_LAST) begin
                    state_d = DMA_IDLE;
                end else if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    idx_d = idx_q + 8'd1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A register write always (re)starts from the top.
        if (reg_we) begin
            state_d = DMA_DELAY;
            src_d   = reg_wdata;
            idx_d   = '0;
            sub_d   = '0;
            dly_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            src_q   <= '0;
            idx_q   <= '0;
            sub_q   <= '0;
            dly_q   <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
            rdata_q <= '0;
            raddr_q <= '0;
            oaddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            dly_q   <= dly_d;
            pend_q  <= rd_en_c;
            if (rd_en_c) pidx_q <= idx_q;
            if (reg_we) rdata_q <= reg_wdata;
            raddr_q <= rd_addr_c;
            oaddr_q <= oam_addr_c;
            wdata_q <= oam_wdata_c;
        end
    end

    // The write side follows the read by the memory latency,
    // so a restart cannot drop a byte already in flight.
    assign rd_en_c     = (state_q == DMA_XFER) && (sub_q == '0);
    assign rd_addr_c   = rd_en_c ? {src_q, idx_q} : raddr_q;
    assign oam_addr_c  = pend_q ? pidx_q : oaddr_q;
    assign oam_wdata_c = pend_q ? bus.rd_data : wdata_q;

    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr   = rd_addr_c;
    assign bus.oam_we    = pend_q;
    assign bus.oam_addr  = oam_addr_c;
    assign bus.oam_wdata = oam_wdata_c;
    assign busy          = (state_q != DMA_IDLE);
    assign reg_rdata     = rdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: schedule-based model checked every cycle
// plus directed transfer, restart, reset and parameter cases.
module tb_oam_dma;

    localparam int LEN = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       we0, we1;
    logic [7:0] wd0, wd1;
    logic [7:0] rr0, rr1;
    logic       busy0, busy1;

    always #5 clk = ~clk;

    oam_dma_if b0();
    oam_dma_if b1();

    oam_dma dut0 (
        .clk(clk), .rst(rst),
        .reg_we(we0), .reg_wdata(wd0),
        .reg_rdata(rr0), .busy(busy0),
        .bus(b0.master)
    );

    oam_dma #(
        .BYTE_CYCLES(2), .START_DELAY(1), .OAM_LEN(160)
    ) dut1 (
        .clk(clk), .rst(rst),
        .reg_we(we1), .reg_wdata(wd1),
        .reg_rdata(rr1), .busy(busy1),
        .bus(b1.master)
    );

    function automatic logic [7:0] f(logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Registered memory and OAM arrays.
    logic [7:0] mem  [65536];
    logic [7:0] oam0 [LEN];
    logic [7:0] oam1 [LEN];

    always @(posedge clk) begin
        if (b0.rd_en) b0.rd_data <= mem[b0.rd_addr];
        if (b1.rd_en) b1.rd_data <= mem[b1.rd_addr];
        if (b0.oam_we) oam0[b0.oam_addr] <= b0.oam_wdata;
        if (b1.oam_we) oam1[b1.oam_addr] <= b1.oam_wdata;
    end

    // Model: position in the transfer schedule per DUT.
    int          dl [2] = '{4, 1};
    int          bc [2] = '{4, 2};
    bit          act [2] = '{0, 0};
    int          t   [2] = '{0, 0};
    logic [7:0]  src [2] = '{0, 0};
    logic [7:0]  rdm [2] = '{0, 0};
    int          trl [2] = '{-1, -1};
    logic [7:0]  tsrc[2] = '{0, 0};
    logic [15:0] lra [2] = '{0, 0};
    logic [7:0]  loa [2] = '{0, 0};
    logic [7:0]  lwd [2] = '{0, 0};

    typedef struct packed {
        logic        busy;
        logic        rd_en;
        logic [15:0] ra;
        logic        we;
        logic [7:0]  oa;
        logic [7:0]  wd;
        logic [7:0]  rr;
    } obs_t;

    function automatic obs_t expect_of(int d);
        obs_t e;
        int k, b, s;
        e.busy  = act[d];
        e.rd_en = 1'b0;
        e.ra    = lra[d];
        e.we    = 1'b0;
        e.oa    = loa[d];
        e.wd    = lwd[d];
        e.rr    = rdm[d];
        if (act[d] && t[d] >= dl[d]) begin
            k = t[d] - dl[d];
            b = k / bc[d];
            s = k % bc[d];
            if (s == 0) begin
                e.rd_en = 1'b1;
                e.ra    = {src[d], 8'(b)};
            end
            if (s == 1) begin
                e.we = 1'b1;
                e.oa = 8'(b);
                e.wd = f({src[d], 8'(b)});
            end
        end
        if (trl[d] >= 0) begin
            e.we = 1'b1;
            e.oa = 8'(trl[d]);
            e.wd = f({tsrc[d], 8'(trl[d])});
        end
        return e;
    endfunction

    function automatic obs_t actual_of(int d);
        obs_t a;
        if (d == 0)
            a = {busy0, b0.rd_en, b0.rd_addr, b0.oam_we,
                 b0.oam_addr, b0.oam_wdata, rr0};
        else
            a = {busy1, b1.rd_en, b1.rd_addr, b1.oam_we,
                 b1.oam_addr, b1.oam_wdata, rr1};
        return a;
    endfunction

    task automatic step(int d, logic r, logic w, logic [7:0] v);
        obs_t e;
        e = expect_of(d);
        if (r) begin
            act[d] = 0; t[d] = 0; src[d] = 0; rdm[d] = 0;
            trl[d] = -1; lra[d] = 0; loa[d] = 0; lwd[d] = 0;
        end else begin
            lra[d] = e.ra;
            loa[d] = e.oa;
            lwd[d] = e.wd;
            trl[d] = -1;
            if (w) begin
                if (e.rd_en) begin
                    trl[d]  = (t[d] - dl[d]) / bc[d];
                    tsrc[d] = src[d];
                end
                act[d] = 1; t[d] = 0;
                src[d] = v; rdm[d] = v;
            end else if (act[d]) begin
                t[d]++;
                if (t[d] == dl[d] + (LEN - 1) * bc[d] + 2)
                    act[d] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        step(0, rst, we0, wd0);
        step(1, rst, we1, wd1);
    end

    int  chk  = 0;
    int  pass = 0;
    bit  armed = 0;
    int  bcnt [2];
    int  rcnt [2];
    int  wcnt [2];
    logic [7:0] snap [LEN];

    task automatic check(string nm, int got, int exp);
        chk++;
        if (got == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      nm, got, exp);
    endtask

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            bcnt[d] = 0; rcnt[d] = 0; wcnt[d] = 0;
        end
    endtask

    task automatic wr(int d, logic [7:0] v);
        if (d == 0) begin we0 = 1'b1; wd0 = v; end
        else begin we1 = 1'b1; wd1 = v; end
        @(negedge clk);
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        while ((d == 0 ? busy0 : busy1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(n < 3000), 1);
    endtask

    task automatic wait_rd(logic [15:0] a);
        int n = 0;
        while (!(b0.rd_en && b0.rd_addr == a) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rd_wait_timeout", int'(n < 3000), 1);
    endtask

    task automatic check_oam(int d, logic [7:0] hi, string nm);
        int errs = 0;
        logic [7:0] v;
        for (int i = 0; i < LEN; i++) begin
            v = (d == 0) ? oam0[i] : oam1[i];
            if (v !== f({hi, 8'(i)})) errs++;
        end
        check(nm, errs, 0);
    endtask

    initial begin
        int lat;
        int errs;
        for (int i = 0; i < 65536; i++) mem[i] = f(16'(i));
        for (int i = 0; i < LEN; i++) begin
            oam0[i] = 8'hEE;
            oam1[i] = 8'hEE;
        end
        clr();
        rst = 1'b1;
        we0 = 1'b0; we1 = 1'b0;
        wd0 = 8'h00; wd1 = 8'h00;

        // Per-cycle compare and event counters.
        fork
            forever begin
                @(negedge clk);
                if (armed) begin
                    for (int d = 0; d < 2; d++) begin
                        obs_t a, e;
                        a = actual_of(d);
                        e = expect_of(d);
                        chk++;
                        if (a === e) pass++;
                        else $display(
                          "FAIL cycle_cmp dut%0d @%0t: got %h expected %h",
                          d, $time, a, e);
                    end
                end
            end
            forever begin
                @(posedge clk);
                if (busy0) bcnt[0]++;
                if (b0.rd_en) rcnt[0]++;
                if (b0.oam_we) wcnt[0]++;
                if (busy1) bcnt[1]++;
                if (b1.rd_en) rcnt[1]++;
                if (b1.oam_we) wcnt[1]++;
            end
        join_none

        repeat (2) @(negedge clk);
        armed = 1'b1;
        check("rst_busy", int'(busy0), 0);
        check("rst_rd_en", int'(b0.rd_en), 0);
        check("rst_oam_we", int'(b0.oam_we), 0);
        check("rst_rd_addr", int'(b0.rd_addr), 0);
        check("rst_oam_addr", int'(b0.oam_addr), 0);
        check("rst_reg_rdata", int'(rr0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic transfer from 0x1200.
        clr();
        wr(0, 8'h12);
        lat = 1;
        while (!b0.rd_en && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("first_rd_latency", lat, 5);
        check("first_rd_addr", int'(b0.rd_addr), 'h1200);
        check("rdata_during", int'(rr0), 'h12);
        wait_idle(0);
        check("busy_cycles", bcnt[0], 642);
        check("rd_pulses", rcnt[0], 160);
        check("we_pulses", wcnt[0], 160);
        check_oam(0, 8'h12, "oam_1200");
        check("oam0_first", int'(oam0[0]), 'h12);
        check("oam0_last", int'(oam0[159]), 'h8D);
        repeat (3) @(negedge clk);
        check("rdata_after", int'(rr0), 'h12);

        // Restart at byte 50.
        wr(0, 8'h12);
        wait_rd(16'h1232);
        clr();
        wr(0, 8'h34);
        check("trail_we", int'(b0.oam_we), 1);
        check("trail_addr", int'(b0.oam_addr), 50);
        check("trail_data", int'(b0.oam_wdata), 'h20);
        check("trail_busy", int'(busy0), 1);
        check("restart_rdata", int'(rr0), 'h34);
        wait_idle(0);
        check("restart_busy", bcnt[0], 643);
        check("restart_rd", rcnt[0], 161);
        check("restart_we", wcnt[0], 161);
        check_oam(0, 8'h34, "oam_3400");
        check("oam0_50", int'(oam0[50]), 'h06);

        // Reset at byte 80.
        for (int i = 0; i < LEN; i++) snap[i] = oam0[i];
        wr(0, 8'h56);
        wait_rd(16'h5650);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy0), 0);
        check("abort_rd_en", int'(b0.rd_en), 0);
        check("abort_oam_we", int'(b0.oam_we), 0);
        check("abort_rdata", int'(rr0), 0);
        repeat (3) @(negedge clk);
        errs = 0;
        for (int i = 0; i < LEN; i++) begin
            if (i < 80 && oam0[i] !== f({8'h56, 8'(i)})) errs++;
            if (i >= 80 && oam0[i] !== snap[i]) errs++;
        end
        check("abort_oam", errs, 0);
        clr();
        wr(0, 8'h20);
        wait_idle(0);
        check("after_abort_busy", bcnt[0], 642);
        check_oam(0, 8'h20, "oam_2000");

        // Reset and write together.
        clr();
        rst = 1'b1;
        we0 = 1'b1;
        wd0 = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        we0 = 1'b0;
        repeat (10) @(negedge clk);
        check("rstwe_busy", int'(busy0), 0);
        check("rstwe_rdata", int'(rr0), 0);
        check("rstwe_busy_cnt", bcnt[0], 0);
        check("rstwe_rd_cnt", rcnt[0], 0);

        // Fast configuration from 0xC000.
        clr();
        wr(1, 8'hC0);
        wait_idle(1);
        check("fast_busy", bcnt[1], 321);
        check("fast_rd", rcnt[1], 160);
        check("fast_we", wcnt[1], 160);
        check_oam(1, 8'hC0, "oam_c000");
        check("oam1_first", int'(oam1[0]), 'hC0);
        check("oam1_last", int'(oam1[159]), 'h5F);
        check("fast_rdata", int'(rr1), 'hC0);

        @(negedge clk);
        armed = 1'b0;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
